// File: rtl/byte_serializer.sv
// ============================================================================
// Module   : byte_serializer (with bit-select mux_8)
// Brief    : Byte-in / bit-out serializer with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_8 (
  input  logic [2:0] select,
  input  logic [7:0] opts,
  output logic       out
);

  assign out = opts[select];

endmodule

module byte_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  output logic       i_ready,
  input  logic [7:0] i_data,
  output logic       o_valid,
  input  logic       o_ready,
  output logic       o_bit,
  output logic       o_last,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] C_LAST_BIT = 3'd7;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_data;
  logic [7:0] w_data_nxt;
  logic [2:0] r_count;
  logic [2:0] w_count_nxt;
  logic [2:0] w_sel;
  logic       w_mux_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= 8'h00;
      r_count <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    i_ready     = 1'b0;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          w_data_nxt  = i_data;
          w_count_nxt = 3'd0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        o_valid = 1'b1;
        busy    = 1'b1;
        o_last  = (r_count == C_LAST_BIT);
        if (o_ready) begin
          if (r_count != C_LAST_BIT) begin
            w_count_nxt = r_count + 3'd1;
          end else begin
            // Final bit leaves this cycle: reload straight away for a zero-bubble handoff.
            i_ready     = 1'b1;
            w_count_nxt = 3'd0;
            if (i_valid) begin
              w_data_nxt = i_data;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_sel = MSB_FIRST ? (C_LAST_BIT - r_count) : r_count;

  mux_8 u_mux_8 (
    .select (w_sel),
    .opts   (r_data),
    .out    (w_mux_bit)
  );

  assign o_bit = o_valid & w_mux_bit;

endmodule

`default_nettype wire

// File: tb/tb_byte_serializer.sv
// ============================================================================
// Module   : tb_byte_serializer
// Brief    : Randomized and directed bench against a bit-queue reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready = 1'b0;
  logic [7:0] i_data = 8'h00;

  logic rdy0, v0, b0, l0, bz0;
  logic rdy1, v1, b1, l1, bz1;

  always #5 clk = ~clk;

  byte_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy0), .i_data(i_data),
    .o_valid(v0), .o_ready(o_ready), .o_bit(b0), .o_last(l0), .busy(bz0)
  );

  byte_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy1), .i_data(i_data),
    .o_valid(v1), .o_ready(o_ready), .o_bit(b1), .o_last(l1), .busy(bz1)
  );

  int          total = 0;
  int          bad = 0;
  bit          msb = 1'b0;
  bit          q[$];
  logic [15:0] cap;
  int          nxfer;
  logic        exp_v, exp_b, exp_l, exp_rdy;
  logic [4:0]  want;
  logic [4:0]  got;

  // Observed tuple of the instance under test: {o_valid, o_bit, o_last, i_ready, busy}
  assign got = msb ? {v1, b1, l1, rdy1, bz1} : {v0, b0, l0, rdy0, bz0};

  // Prediction for the cycle: the queue holds the bits of the current byte still to go.
  task automatic mid();
    @(negedge clk);
    exp_v   = (q.size() != 0);
    exp_b   = exp_v ? q[0] : 1'b0;
    exp_l   = (q.size() == 1);
    exp_rdy = !exp_v || ((q.size() == 1) && o_ready);
    want    = {exp_v, exp_b, exp_l, exp_rdy, exp_v};
  endtask

  task automatic fin();
    if (exp_v && o_ready) begin
      cap = {cap[14:0], got[3]};
      nxfer++;
      void'(q.pop_front());
    end
    if (i_valid && exp_rdy) begin
      for (int i = 0; i < 8; i++) q.push_back(msb ? i_data[7-i] : i_data[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit m);
    rst_n = 1'b0;
    msb = m;
    q.delete();
    cap = 16'h0;
    nxfer = 0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ((got & 5'b11101) !== 5'b00000) begin
      bad++; $display("FAIL reset_hold got=%b exp=000x0", got);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap = 16'h0;
    nxfer = 0;
    for (int c = 0; c < 3; c++) begin
      mid();
      total++;
      if (got !== want) begin bad++; $display("FAIL reset_idle c=%0d got=%b exp=%b", c, got, want); end
      fin();
    end
  endtask

  task automatic test_single();
    do_reset(1'b0);
    i_valid = 1'b1; i_data = 8'hA5; o_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      mid();
      total++;
      if (got !== want) begin bad++; $display("FAIL single c=%0d got=%b exp=%b", c, got, want); end
      fin();
      i_valid = 1'b0;
    end
    total++;
    if (cap[7:0] !== 8'hA5 || nxfer != 8) begin
      bad++; $display("FAIL single_seq got=%h/%0d exp=a5/8", cap[7:0], nxfer);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] bytes [2];
    bytes[0] = 8'hA5;
    bytes[1] = 8'h01;
    do_reset(1'b1);
    o_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cap = 16'h0; nxfer = 0;
      i_valid = 1'b1; i_data = bytes[k];
      for (int c = 0; c < 10; c++) begin
        mid();
        total++;
        if (got !== want) begin bad++; $display("FAIL msb k=%0d c=%0d got=%b exp=%b", k, c, got, want); end
        fin();
        i_valid = 1'b0;
      end
      total++;
      if (cap[7:0] !== bytes[k] || nxfer != 8) begin
        bad++; $display("FAIL msb_seq got=%h/%0d exp=%h/8", cap[7:0], nxfer, bytes[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    do_reset(1'b0);
    i_valid = 1'b1; i_data = 8'hFF; o_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bit acc;
      mid();
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b c=%0d got=%b exp=%b", c, got, want); end
      if (got[4]) nv++;
      acc = i_valid && exp_rdy;
      fin();
      if (acc && i_data == 8'hFF) i_data = 8'h00;
      else if (acc) i_valid = 1'b0;
    end
    total++;
    if (cap !== 16'hFF00 || nxfer != 16 || nv != 16) begin
      bad++; $display("FAIL b2b_seq got=%h/%0d/%0d exp=ff00/16/16", cap, nxfer, nv);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    pat = 4'b1001;
    do_reset(1'b0);
    i_valid = 1'b1; i_data = 8'h3C;
    for (int c = 0; c < 24; c++) begin
      o_ready = pat[3 - (c % 4)];
      mid();
      total++;
      if (got !== want) begin bad++; $display("FAIL bp c=%0d got=%b exp=%b", c, got, want); end
      fin();
      i_valid = 1'b0;
    end
    total++;
    if (cap[7:0] !== 8'h3C || nxfer != 8) begin
      bad++; $display("FAIL bp_seq got=%h/%0d exp=3c/8", cap[7:0], nxfer);
    end
  endtask

  task automatic test_busy_data();
    int acc_c = -1;
    do_reset(1'b0);
    i_valid = 1'b1; i_data = 8'h0F; o_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bit acc;
      mid();
      total++;
      if (got !== want) begin bad++; $display("FAIL busy c=%0d got=%b exp=%b", c, got, want); end
      acc = i_valid && exp_rdy;
      if (acc && i_data == 8'hF0) acc_c = c;
      fin();
      if (acc && i_data == 8'h0F) i_data = 8'hF0;
      else if (acc) i_valid = 1'b0;
    end
    total++;
    if (cap !== 16'hF00F || nxfer != 16 || acc_c != 8) begin
      bad++; $display("FAIL busy_seq got=%h/%0d/%0d exp=f00f/16/8", cap, nxfer, acc_c);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    i_valid = 1'b1; i_data = 8'h55; o_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mid();
      total++;
      if (got !== want) begin bad++; $display("FAIL arst_pre c=%0d got=%b exp=%b", c, got, want); end
      fin();
      i_valid = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ((got & 5'b11101) !== 5'b00000) begin
      bad++; $display("FAIL arst_now got=%b exp=000x0", got);
    end
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cap = 16'h0; nxfer = 0;
    i_valid = 1'b1; i_data = 8'h81;
    for (int c = 0; c < 11; c++) begin
      mid();
      total++;
      if (got !== want) begin bad++; $display("FAIL arst_post c=%0d got=%b exp=%b", c, got, want); end
      fin();
      i_valid = 1'b0;
    end
    total++;
    if (cap[7:0] !== 8'h81 || nxfer != 8) begin
      bad++; $display("FAIL arst_seq got=%h/%0d exp=81/8", cap[7:0], nxfer);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 2; m++) begin
      int nacc = 0;
      do_reset(m[0]);
      for (int c = 0; c < 330; c++) begin
        if (c < 300) begin
          i_valid = 1'($urandom % 2);
          i_data  = 8'($urandom);
          o_ready = (($urandom % 4) != 0);
        end else begin
          i_valid = 1'b0;
          o_ready = 1'b1;
        end
        mid();
        total++;
        if (got !== want) begin bad++; $display("FAIL rand m=%0d c=%0d got=%b exp=%b", m, c, got, want); end
        if (i_valid && exp_rdy) nacc++;
        fin();
      end
      total++;
      if (nxfer != 8 * nacc || q.size() != 0) begin
        bad++; $display("FAIL rand_count m=%0d got=%0d exp=%0d", m, nxfer, 8 * nacc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_busy_data();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
Parallel-to-serial stage that accepts one byte over a valid/ready handshake and emits it one bit per accepted cycle on a valid/ready serial output. Bit selection is done by the existing mux_8 (select = bit index, opts = held byte), with this block owning the holding register, bit counter and control FSM. It sits directly upstream of serial consumers (UART TX, LED/SPI shifters) and downstream of any byte producer.

Parameters:
MSB_FIRST, 0, 0 = emit bit 0 first (select counts 0..7); 1 = emit bit 7 first (select counts 7..0).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream byte valid
i_ready  output  1  block can accept a byte this cycle
i_data  input  8  byte to serialize, sampled on i_valid && i_ready
o_valid  output  1  o_bit holds a valid bit
o_ready  input  1  downstream accepts o_bit this cycle
o_bit  output  1  current serial bit
o_last  output  1  current bit is 8th of the byte (qualified by o_valid)
busy  output  1  a byte is held (state != IDLE)

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low. Assertion forces state immediately regardless of clk.
- Reset values: state=IDLE, data_reg=8'h00, count=3'd0, o_valid=0, o_bit=0, o_last=0, busy=0, i_ready=1 once rst_n deasserted.
- Registers: data_reg[7:0], count[2:0] (bits already sent), state {IDLE, SHIFT}.
- Select to mux_8 = count when MSB_FIRST=0, 3'd7-count when MSB_FIRST=1; opts = data_reg. o_bit = mux_8 output gated by o_valid (o_bit=0 when o_valid=0).
- IDLE: i_ready=1, o_valid=0. On i_valid: data_reg<=i_data, count<=0, state<=SHIFT. First bit valid the cycle after acceptance (latency 1 cycle).
- SHIFT: o_valid=1, busy=1. o_last=1 iff count==7. Bit transfer = o_valid && o_ready.
  - transfer and count!=7: count<=count+1.
  - transfer and count==7: byte done; i_ready=1 this cycle (combinational: i_ready = IDLE || (SHIFT && count==7 && o_ready)).
    - if i_valid also: load new byte, count<=0, stay SHIFT (zero-bubble back-to-back, 8 bits per 8 cycles sustained).
    - else state<=IDLE, count<=0.
  - no transfer (o_ready=0): all state held; o_bit, o_last stable; i_ready=0.
- i_data ignored whenever i_ready=0; data_reg never changes mid-byte.
- o_valid never deasserts once raised until its bit transfers (AXI-style stability).
- count wraps 7->0 only via the done path; no other wrap.
- Reset mid-byte: byte is discarded, no further bits, outputs return to reset values immediately.
- Purely synchronous datapath otherwise; no combinational path i_data -> o_bit.

Test Plan:
- Reset then single byte 8'hA5, o_ready=1, MSB_FIRST=0 -> i_ready drops next cycle; o_bit sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; o_last only on 8th; returns IDLE, i_ready=1.
- Same byte 8'hA5 with MSB_FIRST=1 -> o_bit 1,0,1,0,0,1,0,1 (palindrome check) then 8'h01 -> 0,0,0,0,0,0,0,1.
- Back-to-back 8'hFF then 8'h00 with i_valid held -> 16 consecutive o_valid cycles, bits 8x1 then 8x0, no bubble, o_last on cycles 8 and 16.
- Backpressure: 8'h3C, o_ready toggling 1,0,0,1,... -> bit held stable while o_ready=0, count unchanged, exactly 8 transfers producing 0,0,1,1,1,1,0,0.
- i_data change while busy (8'h0F accepted, i_data driven 8'hF0 with i_valid=1 mid-byte) -> i_ready=0, output remains 1,1,1,1,0,0,0,0, then 8'hF0 accepted on the o_last transfer cycle.
- rst_n pulled low asynchronously (mid-clock) at bit 4 of 8'h55 -> o_valid, o_bit, busy go 0 immediately; after release i_ready=1, next byte 8'h81 serializes correctly from bit 0.
